multicycle_control: RTL
=======================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter MEM_HANDSHAKE, default 1, meaning: 1 = memory states wait for mem_ready; 0 = mem_ready ignored and treated as 1.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports opcode in 6 (IR[31:26]) and func in 6 (IR[5:0]), both sampled from the instruction register.
REQ-005 SHALL have ports zero in 1 (ALU zero flag) and mem_ready in 1 (memory access completes this cycle).
REQ-006 SHALL have outputs pc_en 1, iord 1, mem_read 1, mem_write 1, ir_write 1, reg_dst 1, mem_to_reg 1, reg_write 1, and alu_src_a 1 (0 = PC, 1 = regA).
REQ-007 SHALL have outputs alu_src_b 2 (0 = regB, 1 = const 4, 2 = sign-extended imm, 3 = imm<<2) and pc_source 2 (0 = ALU, 1 = ALUOut, 2 = jump target, 3 = regA).
REQ-008 SHALL have outputs alu_op 3 (0 add, 1 sub, 2 R-type/func, 3 or, 4 sll; this encoding drives the existing ALU control unit), state 4 (debug), illegal_op 1, and retired 1.

Function
REQ-009 SHALL be a Moore FSM with state 4-bit registered encodings: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, LW_WB 4, MEM_WR 5, R_EXEC 6, R_WB 7, BRANCH 8, JUMP 9, ORI_EXEC 10, ORI_WB 11, JR 12; codes 13-15 SHALL go to FETCH next cycle and drive all outputs 0.
REQ-010 SHALL set every output not listed for a state to 0.
REQ-011 FETCH: mem_read=1, alu_src_b=1, alu_op=0, pc_source=0, with ir_write=pc_en=mem_ready; stays in FETCH while mem_ready=0, otherwise goes to DECODE.
REQ-012 DECODE: alu_src_b=3, alu_op=0; next state by opcode: 35/43 -> MEM_ADDR, 0 -> R_EXEC, 4 -> BRANCH, 2 -> JUMP, 13 -> ORI_EXEC; any other opcode -> FETCH with illegal_op=1 for that single cycle.
REQ-013 MEM_ADDR: alu_src_a=1, alu_src_b=2, alu_op=0; goes to MEM_RD if opcode=35, else MEM_WR.
REQ-014 MEM_RD: mem_read=1, iord=1; holds until mem_ready, then goes to LW_WB.
REQ-015 LW_WB: reg_write=1, mem_to_reg=1, reg_dst=0; then FETCH.
REQ-016 MEM_WR: mem_write=1, iord=1; holds until mem_ready, then goes to FETCH.
REQ-017 R_EXEC: alu_src_a=1, alu_src_b=0, alu_op=4 if func=0 (sll), else 2; goes to JR if func=8, else R_WB.
REQ-018 R_WB: reg_write=1, reg_dst=1; then FETCH.
REQ-019 BRANCH: alu_src_a=1, alu_src_b=0, alu_op=1, pc_source=1, pc_en=zero; then FETCH.
REQ-020 JUMP: pc_source=2, pc_en=1; then FETCH; JR: pc_source=3, pc_en=1; then FETCH.
REQ-021 ORI_EXEC: alu_src_a=1, alu_src_b=2, alu_op=3; then ORI_WB; ORI_WB: reg_write=1, reg_dst=0; then FETCH.
REQ-022 retired SHALL pulse 1 for one cycle in each state whose next state is FETCH, excluding the illegal DECODE exit and the stall cycles of MEM_WR.
REQ-023 Memory states SHALL hold their outputs stable for every cycle mem_ready=0, with no cycle limit.
REQ-024 Only pc_en, ir_write and retired MAY depend combinationally on inputs (zero, mem_ready); all other outputs SHALL be functions of state alone.
REQ-025 Instruction latencies with mem_ready=1: lw 5, sw 4, R/sll/ori 4, jr 4, beq 3, j 3 cycles.

Reset
REQ-026 rst=1 at a clock edge SHALL load FETCH; while rst=1, all outputs SHALL be forced to 0.
REQ-027 rst asserted in any state, including a MEM_RD or MEM_WR stall, SHALL abandon the instruction, with no write strobe after the reset edge.
REQ-028 The first cycle after rst deasserts SHALL be FETCH with mem_read=1.

Verification
REQ-029 lw (opcode 35), mem_ready=1 -> states 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in state 4; retired pulses once.
REQ-030 sw with mem_ready held 0 for 3 cycles in MEM_WR -> mem_write=1 and iord=1 for 4 cycles, then FETCH.
REQ-031 R-type func=0 -> alu_op=4 in R_EXEC; func=32 -> alu_op=2; func=8 -> JR with pc_source=3 and pc_en=1, and reg_write never set.
REQ-032 beq with zero=1 -> pc_en=1, pc_source=1 in BRANCH; with zero=0 -> pc_en=0; both return to FETCH.
REQ-033 opcode 63 -> illegal_op=1 for one cycle in DECODE, then FETCH, retired=0.
REQ-034 rst pulse during a MEM_RD stall -> next state FETCH, outputs 0 during reset, and no LW_WB.

Source files
------------

// File: rtl/multicycle_control.sv
// Main control FSM for a multicycle MIPS-style datapath. It is a Moore machine;
// only pc_en, ir_write and retired also follow the zero and mem_ready inputs.
module multicycle_control #(
   parameter int MEM_HANDSHAKE = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   input  logic [5:0] func,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_en,
   output logic       iord,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] pc_source,
   output logic [2:0] alu_op,
   output logic [3:0] state,
   output logic       illegal_op,
   output logic       retired
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEM_ADDR = 4'd2,
      MEM_RD   = 4'd3,
      LW_WB    = 4'd4,
      MEM_WR   = 4'd5,
      R_EXEC   = 4'd6,
      R_WB     = 4'd7,
      BRANCH   = 4'd8,
      JUMP     = 4'd9,
      ORI_EXEC = 4'd10,
      ORI_WB   = 4'd11,
      JR       = 4'd12
   } state_e;

   state_e state_q, state_d;
   logic   mem_rdy;

   assign mem_rdy = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;

   always_ff @(posedge clk) begin
      if (rst) state_q <= FETCH;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d    = FETCH;
      pc_en      = 1'b0;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'd0;
      pc_source  = 2'd0;
      alu_op     = 3'd0;
      state      = state_q;
      illegal_op = 1'b0;
      retired    = 1'b0;
      case (state_q)
         FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'd1;
            ir_write  = mem_rdy;
            pc_en     = mem_rdy;
            state_d   = mem_rdy ? DECODE : FETCH;
         end
         DECODE: begin
            alu_src_b = 2'd3;
            case (opcode)
               6'd35, 6'd43: state_d = MEM_ADDR;
               6'd0:         state_d = R_EXEC;
               6'd4:         state_d = BRANCH;
               6'd2:         state_d = JUMP;
               6'd13:        state_d = ORI_EXEC;
               default: begin
                  state_d    = FETCH;
                  illegal_op = 1'b1;
               end
            endcase
         end
         MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'd2;
            state_d   = (opcode == 6'd35) ? MEM_RD : MEM_WR;
         end
         MEM_RD: begin
            mem_read = 1'b1;
            iord     = 1'b1;
            state_d  = mem_rdy ? LW_WB : MEM_RD;
         end
         LW_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            retired    = 1'b1;
         end
         MEM_WR: begin
            mem_write = 1'b1;
            iord      = 1'b1;
            retired   = mem_rdy;
            state_d   = mem_rdy ? FETCH : MEM_WR;
         end
         R_EXEC: begin
            alu_src_a = 1'b1;
            alu_op    = (func == 6'd0) ? 3'd4 : 3'd2;
            state_d   = (func == 6'd8) ? JR : R_WB;
         end
         R_WB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
            retired   = 1'b1;
         end
         BRANCH: begin
            alu_src_a = 1'b1;
            alu_op    = 3'd1;
            pc_source = 2'd1;
            pc_en     = zero;
            retired   = 1'b1;
         end
         JUMP: begin
            pc_source = 2'd2;
            pc_en     = 1'b1;
            retired   = 1'b1;
         end
         JR: begin
            pc_source = 2'd3;
            pc_en     = 1'b1;
            retired   = 1'b1;
         end
         ORI_EXEC: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'd2;
            alu_op    = 3'd3;
            state_d   = ORI_WB;
         end
         ORI_WB: begin
            reg_write = 1'b1;
            retired   = 1'b1;
         end
         default: begin
            // Unused encodings recover to FETCH with every output quiet.
            state = 4'd0;
         end
      endcase
      if (rst) begin
         pc_en      = 1'b0;
         iord       = 1'b0;
         mem_read   = 1'b0;
         mem_write  = 1'b0;
         ir_write   = 1'b0;
         reg_dst    = 1'b0;
         mem_to_reg = 1'b0;
         reg_write  = 1'b0;
         alu_src_a  = 1'b0;
         alu_src_b  = 2'd0;
         pc_source  = 2'd0;
         alu_op     = 3'd0;
         state      = 4'd0;
         illegal_op = 1'b0;
         retired    = 1'b0;
      end
   end

endmodule
